// File: rtl/axi_mem_bridge.sv
// axi_mem_bridge: single-outstanding AXI3/AXI4 master for CPU fetch and data accesses.
// Latency: request seen in IDLE -> AR/AW+W on the next cycle; result latched on the R/B beat.
// Backpressure: a stalled AXI channel holds the FSM in place; i_stall/d_stall stay high until done.
//
// Ports: clk/rst (async active-high); fetch side inst_en/inst_addr -> inst_rdata/i_stall;
//        data side data_en/data_addr/data_wen/data_wdata -> data_rdata/d_stall; longest_stall
//        from the datapath releases the done flags; full AR/R/AW/W/B AXI master channels.
// Build option: define AXI_BRIDGE_KSEG_MAP_EN to map kseg0/kseg1 addresses to physical.
module axi_mem_bridge (
    input  logic        clk,
    input  logic        rst,
    // fetch side
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        i_stall,
    // data side
    input  logic        data_en,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B} state_t;

    state_t state;
    logic   inst_done;
    logic   data_done;
    logic   inst_fin;
    logic   data_fin;

    // Single-beat INCR transfers only; IDs/responses from the slave carry no information
    // for a single-outstanding master.
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = 4'd1;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wlast   = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, bid, bresp, inst_addr[1:0]};

    assign i_stall = inst_en & ~inst_done;
    assign d_stall = data_en & ~data_done;

    // rready/bready are only ever high inside the R/B states, so the slave valid alone
    // marks the completing beat.
    assign inst_fin = (state == I_R) & rvalid;
    assign data_fin = ((state == D_R) & rvalid) | ((state == D_B) & bvalid);

    function automatic logic [31:0] phys(input logic [31:0] a);
`ifdef AXI_BRIDGE_KSEG_MAP_EN
        // kseg0/kseg1 (top bits 10x) are unmapped windows onto the low 512 MB.
        phys = (a[31:30] == 2'b10) ? {3'b000, a[28:0]} : a;
`else
        phys = a;
`endif
    endfunction

    function automatic logic [2:0] wsize(input logic [3:0] wen);
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wsize = 3'd0;
            4'b0011, 4'b1100:                   wsize = 3'd1;
            default:                            wsize = 3'd2;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            arid       <= 4'd0;
            araddr     <= 32'd0;
            arsize     <= 3'd2;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= 32'd0;
            awsize     <= 3'd0;
            awvalid    <= 1'b0;
            wdata      <= 32'd0;
            wstrb      <= 4'd0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            // A low longest_stall means the pipeline moves this edge, so results are
            // consumed; it cannot coincide with our own completion of a live request.
            inst_done <= longest_stall ? (inst_done | inst_fin) : 1'b0;
            data_done <= longest_stall ? (data_done | data_fin) : 1'b0;

            case (state)
                IDLE: begin
                    if (data_en && !data_done) begin
                        if (data_wen == 4'd0) begin
                            state   <= D_AR;
                            arvalid <= 1'b1;
                            arid    <= 4'd1;
                            arsize  <= 3'd2;
                            araddr  <= phys({data_addr[31:2], 2'b00});
                        end else begin
                            state   <= D_W;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= phys(data_addr);
                            awsize  <= wsize(data_wen);
                            wstrb   <= data_wen;
                            wdata   <= data_wdata;
                        end
                    end else if (inst_en && !inst_done) begin
                        state   <= I_AR;
                        arvalid <= 1'b1;
                        arid    <= 4'd0;
                        arsize  <= 3'd2;
                        araddr  <= phys({inst_addr[31:2], 2'b00});
                    end
                end
                I_AR, D_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= (state == I_AR) ? I_R : D_R;
                    end
                end
                I_R: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        inst_rdata <= rdata;
                        state      <= IDLE;
                    end
                end
                D_R: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        data_rdata <= rdata;
                        state      <= IDLE;
                    end
                end
                D_W: begin
                    // AW and W complete independently; leave once neither is outstanding.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= D_B;
                    end
                end
                D_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_bridge.sv
module tb_axi_mem_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_en;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_en;
    logic [31:0] data_addr;
    logic [3:0]  data_wen;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_mem_bridge dut (
        .clk(clk), .rst(rst),
        .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
        .data_en(data_en), .data_addr(data_addr), .data_wen(data_wen), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .d_stall(d_stall), .longest_stall(longest_stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave memory (written over AXI) and reference memory (written by the model).
    logic [31:0] smem [int unsigned];
    logic [31:0] rmem [int unsigned];

    bit          hs_ar, hs_r, hs_aw, hs_w, hs_b;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    bit          r_busy, aw_got, w_got, b_busy;
    int          r_cnt, b_cnt;
    logic [31:0] r_word;

    function automatic logic [31:0] seed_word(input int unsigned k);
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] tmap(input logic [31:0] a);
`ifdef AXI_BRIDGE_KSEG_MAP_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a - (a & 32'hE000_0000);
`endif
        return a;
    endfunction

    function automatic logic [31:0] rand_addr_base();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'h8000_0100;
            2:       return 32'hA000_0100;
            default: return 32'hC000_0100;
        endcase
    endfunction

    function logic [31:0] smem_rd(input int unsigned k);
        return smem.exists(k) ? smem[k] : seed_word(k);
    endfunction

    function logic [31:0] rmem_rd(input int unsigned k);
        return rmem.exists(k) ? rmem[k] : seed_word(k);
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic slave_quiet();
        arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
    endtask

    // Randomised AXI slave, advanced once per cycle at the falling edge using the
    // handshakes recorded just before the preceding rising edge.
    task automatic slave_step();
        logic [31:0] w;
        int unsigned k;
        if (hs_r) begin r_busy = 0; rvalid = 0; end
        if (hs_ar) begin
            r_busy = 1;
            r_cnt  = $urandom_range(0, 3);
            r_word = smem_rd(int'(cap_araddr >> 2));
        end
        if (r_busy && !rvalid) begin
            if (r_cnt == 0) begin rvalid = 1; rdata = r_word; end
            else r_cnt--;
        end
        arready = arvalid && ($urandom_range(0, 2) != 0);
        if (hs_aw) aw_got = 1;
        if (hs_w) w_got = 1;
        if (aw_got && w_got) begin
            k = cap_awaddr >> 2;
            w = smem_rd(k);
            for (int i = 0; i < 4; i++) if (cap_wstrb[i]) w[8*i +: 8] = cap_wdata[8*i +: 8];
            smem[k] = w;
            aw_got = 0; w_got = 0;
            b_busy = 1; b_cnt = $urandom_range(0, 3);
        end
        if (hs_b) begin b_busy = 0; bvalid = 0; end
        if (b_busy && !bvalid) begin
            if (b_cnt == 0) bvalid = 1;
            else b_cnt--;
        end
        awready = awvalid && ($urandom_range(0, 2) != 0);
        wready  = wvalid && ($urandom_range(0, 2) != 0);
    endtask

    task automatic test_reset();
        rst = 1; inst_en = 1; inst_addr = 0; data_en = 0; data_addr = 0; data_wen = 0;
        data_wdata = 0; longest_stall = 0; slave_quiet();
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL reset_valids got %b exp 00000", {arvalid, awvalid, wvalid, rready, bready}); end
        checks++; if (inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", inst_rdata, data_rdata); end
        checks++; if (i_stall !== 1'b1 || d_stall !== 1'b0) begin errors++; $display("FAIL reset_stalls got %b%b exp 10", i_stall, d_stall); end
        inst_en = 0;
        @(negedge clk);
        rst = 0;
        cyc();
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_idle_ar got %b exp 0", arvalid); end
    endtask

    task automatic test_fetch();
        inst_en = 1; inst_addr = 32'hBFC0_0000; longest_stall = 1;
        #1;
        checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c0 got %b exp 1", i_stall); end
        cyc();  // cycle 1
        checks++; if (arvalid !== 1'b1 || arid !== 4'd0) begin errors++; $display("FAIL fetch_ar_c1 got v%b id%h exp v1 id0", arvalid, arid); end
        checks++; if (araddr !== tmap(32'hBFC0_0000)) begin errors++; $display("FAIL fetch_araddr got %h exp %h", araddr, tmap(32'hBFC0_0000)); end
        checks++; if ({arlen, arsize, arburst} !== {8'd0, 3'd2, 2'b01}) begin errors++; $display("FAIL fetch_arfields got %h/%h/%h exp 0/2/1", arlen, arsize, arburst); end
        arready = 1;
        #1;
        checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c1 got %b exp 1", i_stall); end
        cyc();  // cycle 2
        arready = 0;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1 || i_stall !== 1'b1) begin errors++; $display("FAIL fetch_c2 got ar%b rr%b st%b exp 010", arvalid, rready, i_stall); end
        cyc();  // cycle 3
        rvalid = 1; rdata = 32'h2408_0001;
        #1;
        checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_c3 got %b exp 1", i_stall); end
        cyc();  // cycle 4
        rvalid = 0;
        #1;
        checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_c4 got %b exp 0", i_stall); end
        checks++; if (inst_rdata !== 32'h2408_0001) begin errors++; $display("FAIL fetch_rdata got %h exp 24080001", inst_rdata); end
        longest_stall = 0;
        cyc();
        inst_en = 0;
    endtask

    task automatic test_priority();
        inst_en = 1; inst_addr = 32'h0000_1000;
        data_en = 1; data_wen = 0; data_addr = 32'h8000_0010; longest_stall = 1;
        cyc();  // cycle 1
        checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== tmap(32'h8000_0010)) begin errors++; $display("FAIL prio_data_ar got v%b id%h a%h exp v1 id1 a%h", arvalid, arid, araddr, tmap(32'h8000_0010)); end
        arready = 1;
        cyc();  // cycle 2
        arready = 0;
        checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL prio_dr got ar%b rr%b exp 01", arvalid, rready); end
        cyc();  // cycle 3: R still pending
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL prio_no_fetch_ar got %b exp 0", arvalid); end
        rvalid = 1; rdata = 32'hDA7A_0010;
        cyc();  // cycle 4
        rvalid = 0;
        #1;
        checks++; if (d_stall !== 1'b0 || i_stall !== 1'b1 || data_rdata !== 32'hDA7A_0010) begin errors++; $display("FAIL prio_data_done got d%b i%b %h exp 0 1 da7a0010", d_stall, i_stall, data_rdata); end
        cyc();  // cycle 5
        checks++; if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h0000_1000) begin errors++; $display("FAIL prio_fetch_ar got v%b id%h a%h exp v1 id0 a00001000", arvalid, arid, araddr); end
        arready = 1;
        cyc();
        arready = 0; rvalid = 1; rdata = 32'h1234_5678;
        cyc();
        rvalid = 0;
        #1;
        checks++; if (i_stall !== 1'b0 || d_stall !== 1'b0 || inst_rdata !== 32'h1234_5678 || data_rdata !== 32'hDA7A_0010) begin errors++; $display("FAIL prio_both_done got i%b d%b %h %h", i_stall, d_stall, inst_rdata, data_rdata); end
        longest_stall = 0;
        cyc();
        inst_en = 0; data_en = 0;
    endtask

    task automatic test_sb();
        data_en = 1; data_wen = 4'b0100; data_wdata = 32'h00AB_0000; data_addr = 32'h1000_0002;
        longest_stall = 1;
        cyc();  // cycle 1
        checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awsize !== 3'd0 || wstrb !== 4'b0100) begin errors++; $display("FAIL sb_c1 got aw%b w%b sz%0d st%b exp 1 1 0 0100", awvalid, wvalid, awsize, wstrb); end
        checks++; if (awaddr !== 32'h1000_0002 || wdata !== 32'h00AB_0000 || wlast !== 1'b1 || awid !== 4'd1 || wid !== 4'd1) begin errors++; $display("FAIL sb_fields got a%h d%h l%b id%h/%h", awaddr, wdata, wlast, awid, wid); end
        wready = 1;
        cyc();  // cycle 2
        wready = 0;
        checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1) begin errors++; $display("FAIL sb_w_only got w%b aw%b exp 0 1", wvalid, awvalid); end
        cyc();  // cycle 3
        checks++; if (awvalid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL sb_aw_hold got aw%b b%b exp 1 0", awvalid, bready); end
        awready = 1;
        cyc();  // cycle 4
        awready = 0;
        checks++; if (awvalid !== 1'b0 || bready !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL sb_b_wait got aw%b b%b st%b exp 0 1 1", awvalid, bready, d_stall); end
        bvalid = 1;
        cyc();  // cycle 5
        bvalid = 0;
        #1;
        checks++; if (d_stall !== 1'b0 || bready !== 1'b0) begin errors++; $display("FAIL sb_done got st%b b%b exp 0 0", d_stall, bready); end
        longest_stall = 0;
        cyc();
        data_en = 0;
    endtask

    task automatic test_done_hold();
        logic [31:0] v;
        v = $urandom;
        inst_en = 1; inst_addr = 32'h0000_2000; longest_stall = 1;
        cyc();
        arready = 1;
        cyc();
        arready = 0; rvalid = 1; rdata = v;
        cyc();
        rvalid = 0; rdata = ~v;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if (arvalid !== 1'b0 || i_stall !== 1'b0 || inst_rdata !== v) begin errors++; $display("FAIL hold_%0d got ar%b st%b %h exp 0 0 %h", i, arvalid, i_stall, inst_rdata, v); end
        end
        longest_stall = 0;
        cyc();
        #1;
        checks++; if (i_stall !== 1'b1) begin errors++; $display("FAIL hold_clear got %b exp 1", i_stall); end
        inst_en = 0;
        cyc();
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL hold_no_reissue got %b exp 0", arvalid); end
    endtask

    task automatic test_rst_mid();
        inst_en = 1; inst_addr = 32'h0000_0040; longest_stall = 1;
        cyc();
        arready = 1;
        cyc();
        arready = 0; rvalid = 1; rdata = 32'hCAFE_0040;
        cyc();
        rvalid = 0;
        data_en = 1; data_wen = 0; data_addr = 32'h0000_3000;
        #1;
        checks++; if (i_stall !== 1'b0) begin errors++; $display("FAIL rstm_fetch_done got %b exp 0", i_stall); end
        cyc();
        checks++; if (arvalid !== 1'b1 || arid !== 4'd1) begin errors++; $display("FAIL rstm_dar got v%b id%h exp 1 1", arvalid, arid); end
        arready = 1;
        cyc();
        arready = 0;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rstm_in_dr got %b exp 1", rready); end
        rst = 1;
        #1;
        checks++; if (rready !== 1'b0 || arvalid !== 1'b0 || i_stall !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL rstm_async got rr%b ar%b i%b d%b exp 0 0 1 1", rready, arvalid, i_stall, d_stall); end
        inst_en = 0;
        cyc();
        rst = 0;
        cyc();
        checks++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h0000_3000) begin errors++; $display("FAIL rstm_idle_reissue got v%b id%h a%h", arvalid, arid, araddr); end
        arready = 1;
        cyc();
        arready = 0; rvalid = 1; rdata = 32'h0BAD_3000;
        cyc();
        rvalid = 0;
        #1;
        checks++; if (d_stall !== 1'b0 || data_rdata !== 32'h0BAD_3000) begin errors++; $display("FAIL rstm_after got st%b %h exp 0 0bad3000", d_stall, data_rdata); end
        longest_stall = 0; data_en = 0;
        cyc();
    endtask

    task automatic test_random();
        bit          ie, de, dw, ext, fin, dcomp, last_data_rd;
        logic [31:0] ia, da, dwd, exp_i, exp_d, w;
        logic [3:0]  wen;
        int          n_iar, n_dar, n_dw, lane, kind;
        int unsigned k;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
        r_busy = 0; aw_got = 0; w_got = 0; b_busy = 0; last_data_rd = 0;
        slave_quiet();
        for (int step = 0; step < 150; step++) begin
            ie = ($urandom_range(0, 3) != 0);
            de = ($urandom_range(0, 2) != 0);
            dw = de && ($urandom_range(0, 1) == 1);
            ia = rand_addr_base() + ($urandom_range(0, 15) << 2);
            da = rand_addr_base() + ($urandom_range(0, 15) << 2);
            dwd = $urandom;
            wen = 4'd0;
            if (dw) begin
                kind = $urandom_range(0, 2);
                if (kind == 0) begin lane = $urandom_range(0, 3); wen = 4'b0001 << lane; da = da + lane; end
                else if (kind == 1) begin
                    if ($urandom_range(0, 1) == 1) begin wen = 4'b1100; da = da + 2; end
                    else wen = 4'b0011;
                end else wen = 4'b1111;
            end
            // Reference: data access happens before the fetch of the same step.
            exp_d = 32'd0;
            if (dw) begin
                k = tmap(da) >> 2;
                w = rmem_rd(k);
                for (int i = 0; i < 4; i++) if (wen[i]) w[8*i +: 8] = dwd[8*i +: 8];
                rmem[k] = w;
            end else if (de) exp_d = rmem_rd(tmap(da) >> 2);
            exp_i = rmem_rd(tmap(ia) >> 2);

            inst_en = ie; inst_addr = ia; data_en = de; data_addr = da; data_wen = wen; data_wdata = dwd;
            n_iar = 0; n_dar = 0; n_dw = 0; dcomp = 0; fin = 0;
            for (int c = 0; c < 200 && !fin; c++) begin
                slave_step();
                ext = ($urandom_range(0, 3) == 0);
                #1;
                longest_stall = i_stall | d_stall | ext;
                hs_ar = arvalid && arready;
                hs_r  = rvalid && rready;
                hs_aw = awvalid && awready;
                hs_w  = wvalid && wready;
                hs_b  = bvalid && bready;
                if (hs_ar) begin
                    cap_araddr = araddr;
                    last_data_rd = (arid == 4'd1);
                    checks++; if ({arlen, arsize, arburst, arlock, arcache, arprot} !== {8'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'd0}) begin errors++; $display("FAIL rnd_arfields step %0d got %h %h %h", step, arlen, arsize, arburst); end
                    if (arid == 4'd1) begin
                        n_dar++;
                        checks++; if (araddr !== tmap({da[31:2], 2'b00})) begin errors++; $display("FAIL rnd_d_araddr step %0d got %h exp %h", step, araddr, tmap({da[31:2], 2'b00})); end
                    end else begin
                        n_iar++;
                        checks++; if (araddr !== tmap({ia[31:2], 2'b00}) || arid !== 4'd0) begin errors++; $display("FAIL rnd_i_ar step %0d got %h id%h exp %h id0", step, araddr, arid, tmap({ia[31:2], 2'b00})); end
                        checks++; if (de && !dcomp) begin errors++; $display("FAIL rnd_order step %0d got fetch-before-data exp data-first", step); end
                    end
                end
                if (hs_r && last_data_rd) dcomp = 1;
                if (hs_b) dcomp = 1;
                if (hs_aw) begin
                    cap_awaddr = awaddr;
                    n_dw++;
                    checks++; if (awaddr !== tmap(da) || awsize !== ($countones(wen) == 1 ? 3'd0 : $countones(wen) == 2 ? 3'd1 : 3'd2) || awid !== 4'd1) begin errors++; $display("FAIL rnd_aw step %0d got %h sz%0d id%h exp %h wen%b", step, awaddr, awsize, awid, tmap(da), wen); end
                end
                if (hs_w) begin
                    cap_wdata = wdata; cap_wstrb = wstrb;
                    checks++; if (wdata !== dwd || wstrb !== wen || wlast !== 1'b1 || wid !== 4'd1) begin errors++; $display("FAIL rnd_w step %0d got %h %b exp %h %b", step, wdata, wstrb, dwd, wen); end
                end
                if (!longest_stall) begin
                    fin = 1;
                    if (ie) begin
                        checks++; if (inst_rdata !== exp_i) begin errors++; $display("FAIL rnd_inst_rdata step %0d got %h exp %h", step, inst_rdata, exp_i); end
                    end
                    if (de && !dw) begin
                        checks++; if (data_rdata !== exp_d) begin errors++; $display("FAIL rnd_data_rdata step %0d got %h exp %h", step, data_rdata, exp_d); end
                    end
                    checks++; if (n_iar !== (ie ? 1 : 0) || n_dar !== ((de && !dw) ? 1 : 0) || n_dw !== (dw ? 1 : 0)) begin errors++; $display("FAIL rnd_txn_count step %0d got i%0d dr%0d dw%0d", step, n_iar, n_dar, n_dw); end
                end
                cyc();
            end
            if (!fin) begin
                errors++; checks++;
                $display("FAIL rnd_timeout step %0d got no advance exp advance within 200 cycles", step);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "timeout");
            end
        end
        inst_en = 0; data_en = 0; longest_stall = 0;
        cyc();
        // The slave memory must now hold exactly what the reference model predicts.
        foreach (rmem[key]) begin
            checks++; if (smem_rd(key) !== rmem[key]) begin errors++; $display("FAIL rnd_mem word %h got %h exp %h", key, smem_rd(key), rmem[key]); end
        end
    endtask

    initial begin
        rid = 0; rresp = 0; rlast = 1; bid = 0; bresp = 0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_priority();
        test_sb();
        test_done_hold();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_bridge.md
# axi_mem_bridge

Single-outstanding AXI3/AXI4 master that sits directly below the CPU datapath. It converts the pipeline's instruction-fetch request (`pcF`/`inst_enF`) and memory-stage data request (`mem_*M`) into 32-bit AXI transactions. It returns read data and generates the `i_stall`/`d_stall` signals the datapath's hazard unit consumes. Completed results are held until the whole pipeline advances, which `longest_stall` going low indicates.

## Interface
- No parameters; ID width 4, data width 32, address width 32.
- `clk` in 1 — core clock, all state on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `inst_en` in 1 — fetch request (datapath `inst_enF`).
- `inst_addr` in 32 — fetch address (`pcF`).
- `inst_rdata` out 32 — registered fetch data (`instrF`).
- `i_stall` out 1 — fetch not yet complete.
- `data_en` in 1 — data access request (`mem_enM`).
- `data_addr` in 32 — byte address (`mem_addrM`).
- `data_wen` in 4 — byte strobes; 0 = read (`mem_wenM`).
- `data_wdata` in 32 — store data, already lane-aligned (`mem_wdataM`).
- `data_rdata` out 32 — registered load data (`mem_rdataM`).
- `d_stall` out 1 — data access not yet complete.
- `longest_stall` in 1 — OR of all pipeline stalls from the datapath.
- AXI read address: `arid`[3:0], `araddr`[31:0], `arlen`[7:0], `arsize`[2:0], `arburst`[1:0], `arlock`[1:0], `arcache`[3:0], `arprot`[2:0], `arvalid` out; `arready` in.
- AXI read data: `rid`[3:0], `rdata`[31:0], `rresp`[1:0], `rlast`, `rvalid` in; `rready` out.
- AXI write address: `awid`[3:0], `awaddr`[31:0], `awlen`[7:0], `awsize`[2:0], `awburst`[1:0], `awlock`[1:0], `awcache`[3:0], `awprot`[2:0], `awvalid` out; `awready` in.
- AXI write data: `wid`[3:0], `wdata`[31:0], `wstrb`[3:0], `wlast`, `wvalid` out; `wready` in.
- AXI write response: `bid`[3:0], `bresp`[1:0], `bvalid` in; `bready` out.

## Operation
- Constant fields on every transaction: len 0, burst INCR (2'b01), lock 0, cache 0, prot 0, `wlast` 1.
- IDs: fetch `arid` 0; data `arid`/`awid`/`wid` 1. `rid`, `bid`, `rresp` and `bresp` are ignored.
- Done flags `inst_done` and `data_done`:
  - Set when the respective transaction completes.
  - Both cleared at any edge where `longest_stall`=0.
- Stall outputs (combinational):
  - `i_stall = inst_en & ~inst_done`
  - `d_stall = data_en & ~data_done`
- FSM states: IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B.
- IDLE arbitration:
  - If `data_en & ~data_done`: go to D_AR when `data_wen`=0, otherwise D_W.
  - Else if `inst_en & ~inst_done`: go to I_AR.
  - Data always has priority over fetch.
- Request capture:
  - On leaving IDLE, the address, strobes and wdata are latched.
  - Upstream changes during a transaction are ignored.
- Read path:
  - I_AR/D_AR: `arvalid`=1 until `arready`, then the R state.
  - I_R/D_R: `rready`=1. On `rvalid`:
    - `rdata` goes into `inst_rdata` or `data_rdata`.
    - The done flag is set.
    - FSM returns to IDLE.
- Write path:
  - D_W: `awvalid` and `wvalid` both assert on entry.
  - Each deasserts independently after its own handshake.
  - Both handshakes may occur in the same cycle.
  - After both are done, go to D_B.
  - D_B: `bready`=1. On `bvalid`, set `data_done` and return to IDLE.
- Write size derived from `wen`:
  - one bit set → `awsize` 0
  - 4'b0011 or 4'b1100 → 1
  - 4'b1111 → 2
  - `awaddr` is the byte address as given.
- Read size is always `arsize`=2. `araddr` is the given address with [1:0] forced to 0.
- Transactions are never aborted: once issued, each transaction runs to completion even if the request drops.
  - If the request drops, the result is still latched and the done flag set.
  - That flag is cleared by the next `longest_stall`=0 edge.

## Timing
- Reset values:
  - FSM state IDLE
  - all AXI valids and `rready`/`bready` 0
  - `inst_done`/`data_done` 0
  - `inst_rdata`/`data_rdata` 0
- Best-case read:
  - Request seen in IDLE at cycle 0.
  - `arvalid` at cycle 1; `arready` also at cycle 1.
  - `rvalid` at cycle 2.
  - Stall low from cycle 3, with data valid at cycle 3.
- Best-case write: AW and W handshake at cycle 1, `bvalid` at cycle 2, `d_stall` low at cycle 3.
- The done-flag clear has priority over a same-cycle set only when `longest_stall`=0. That can happen only for a flag not currently being set, because `longest_stall` covers the own stall.
- An asynchronous `rst` mid-transaction drops all valids immediately. The interconnect is reset together with the core.

## Configuration
- `AXI_BRIDGE_KSEG_MAP_EN`:
  - Defined: `araddr`/`awaddr` in 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) are mapped to physical by clearing bits [31:29]; other addresses pass unchanged.
  - Undefined: addresses pass through untranslated.

## Test plan
- Fetch 0xBFC0_0000, slave `arready` at cycle 1, `rvalid` at cycle 3 with `rdata`=0x2408_0001:
  - `i_stall` high cycles 0–3, low at cycle 4.
  - `inst_rdata`=0x2408_0001.
  - With the macro, `araddr`=0x1FC0_0000 and `arid`=0.
- Simultaneous `inst_en` and `data_en` (read at 0x8000_0010):
  - Data AR issued first with `arid`=1.
  - Fetch AR follows only after the data R handshake.
  - `longest_stall` stays high until both are done.
- `sb` with `wen`=4'b0100, `wdata`=0x00AB_0000, `addr`=0x...02:
  - `awsize`=0, `wstrb`=4'b0100.
  - `awready` 2 cycles after `wready`; still exactly one B wait.
  - `d_stall` drops the cycle after `bvalid`.
- Done hold: the fetch completes while `longest_stall` is held high for 5 cycles by external stalls.
  - No second AR is issued.
  - `inst_rdata` is stable.
  - The flag clears on the edge after `longest_stall`=0.
- Assert `rst` while in D_R: `rready` and done flags go 0 immediately, and FSM is IDLE after release.
